seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 62 ++++++
 tb/tb_seg_scan_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed 8-digit 7-segment scan controller with an
//               8 x 4-bit digit store, per-digit blanking and frame pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int CLK_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [7:0] digit_en,
  input  logic       hold,
  output logic [3:0] num,
  output logic [2:0] sel,
  output logic       blank,
  output logic       frame_done
);

  // A single-cycle slot still needs a 1-bit counter that simply stays at 0.
  localparam int             CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0]     SEL_LAST = 3'd7;

  logic [CNT_W-1:0] div_cnt;
  logic [3:0]       store [8];
  logic             tick;

  assign tick = (div_cnt == CNT_MAX) && !hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      sel        <= '0;
      frame_done <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        store[i] <= '0;
      end
    end else begin
      if (!hold) begin
        div_cnt <= (div_cnt == CNT_MAX) ? '0 : div_cnt + 1'b1;
      end
      if (tick) begin
        sel <= sel + 3'd1;
      end
      frame_done <= tick && (sel == SEL_LAST);
      // Writes are independent of scanning, so they land even while held.
      if (wr_en) begin
        store[wr_addr] <= wr_data;
      end
    end
  end

  assign num   = store[sel];
  assign blank = ~digit_en[sel];

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Scoreboard bench for seg_scan_ctrl with CLK_DIV = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [7:0] digit_en = 8'hFF;
  logic       hold = 1'b0;
  logic [3:0] num;
  logic [2:0] sel;
  logic       blank;
  logic       frame_done;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] num;
    logic       blank;
    logic       fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference: active (unheld) edges since reset fix both div_cnt and sel.
  int         m_active;
  logic [3:0] m_store [8];
  logic       m_fd;

  seg_scan_ctrl #(.CLK_DIV(DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .digit_en  (digit_en),
    .hold      (hold),
    .num       (num),
    .sel       (sel),
    .blank     (blank),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_active = 0;
    m_fd     = 1'b0;
    for (int i = 0; i < 8; i++) m_store[i] = 4'h0;
  endfunction

  function automatic exp_t model_expect();
    exp_t       e;
    logic [2:0] s;
    s       = 3'((m_active / DIV) % 8);
    e.sel   = s;
    e.num   = m_store[s];
    e.blank = ~digit_en[s];
    e.fd    = m_fd;
    return e;
  endfunction

  // Predict the state after the coming edge from the inputs now driven.
  function automatic void model_advance();
    logic [2:0] s;
    s = 3'((m_active / DIV) % 8);
    if (!hold) begin
      m_fd = ((m_active % DIV) == DIV - 1) && (s == 3'd7);
      m_active++;
    end else begin
      m_fd = 1'b0;
    end
    if (wr_en) m_store[wr_addr] = wr_data;
  endfunction

  task automatic do_reset();
    wr_en = 1'b0;
    hold  = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Loads store[i] = i+1 with scanning frozen so the scan starts at slot 0.
  task automatic load_count();
    hold = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_addr = 3'(i);
      wr_data = 4'(i + 1);
      model_advance();
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got;
    rst_n    = 1'b1;
    digit_en = 8'hFE;
    wr_en    = 1'b1;
    wr_addr  = 3'd0;
    wr_data  = 4'h9;
    #1 rst_n = 1'b0;
    #1;
    got = {sel, num, blank, frame_done};
    n_cmp++;
    if (got !== {3'd0, 4'h0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_async: got sel=%0d num=%h blank=%b fd=%b, expected sel=0 num=0 blank=1 fd=0",
               sel, num, blank, frame_done);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wr_en = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (num !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_write_ignored: got num=%h, expected 0", num);
    end
  endtask

  task automatic test_scan();
    exp_t e, got;
    int   pulses;
    pulses = 0;
    do_reset();
    load_count();
    hold = 1'b0;
    for (int j = 0; j < 18 * DIV; j++) begin
      digit_en = (j < 9 * DIV) ? 8'hFF : 8'b1010_1010;
      exp_q.push_back(model_expect());
      #1;
      got = {sel, num, blank, frame_done};
      e   = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL scan j=%0d: got sel=%0d num=%h blank=%b fd=%b, expected sel=%0d num=%h blank=%b fd=%b",
                 j, got.sel, got.num, got.blank, got.fd, e.sel, e.num, e.blank, e.fd);
      end
      if (frame_done === 1'b1) pulses++;
      model_advance();
      @(posedge clk); #1;
    end
    n_cmp++;
    if (pulses !== 2) begin
      n_bad++;
      $display("FAIL scan_frame_count: got %0d pulses, expected 2", pulses);
    end
  endtask

  task automatic test_hold();
    exp_t e, got;
    do_reset();
    load_count();
    digit_en = 8'hFF;
    for (int j = 0; j < 40; j++) begin
      hold    = (j >= 13) && (j <= 22);
      wr_en   = (j == 18);
      wr_addr = 3'd3;
      wr_data = 4'hA;
      exp_q.push_back(model_expect());
      #1;
      got = {sel, num, blank, frame_done};
      e   = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL hold j=%0d: got sel=%0d num=%h blank=%b fd=%b, expected sel=%0d num=%h blank=%b fd=%b",
                 j, got.sel, got.num, got.blank, got.fd, e.sel, e.num, e.blank, e.fd);
      end
      if (j == 25 || j == 26) begin
        n_cmp++;
        if (sel !== ((j == 25) ? 3'd3 : 3'd4)) begin
          n_bad++;
          $display("FAIL hold_release j=%0d: got sel=%0d, expected %0d", j, sel, (j == 25) ? 3 : 4);
        end
      end
      model_advance();
      @(posedge clk); #1;
    end
    hold  = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic test_write_on_advance();
    exp_t e, got;
    do_reset();
    load_count();
    hold = 1'b0;
    for (int j = 0; j < 3 * DIV; j++) begin
      wr_en   = (j == 2 * DIV - 1);
      wr_addr = 3'd2;
      wr_data = 4'hF;
      exp_q.push_back(model_expect());
      #1;
      got = {sel, num, blank, frame_done};
      e   = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL wr_advance j=%0d: got sel=%0d num=%h blank=%b fd=%b, expected sel=%0d num=%h blank=%b fd=%b",
                 j, got.sel, got.num, got.blank, got.fd, e.sel, e.num, e.blank, e.fd);
      end
      if (j == 2 * DIV) begin
        n_cmp++;
        if ({sel, num} !== {3'd2, 4'hF}) begin
          n_bad++;
          $display("FAIL wr_advance_first: got sel=%0d num=%h, expected sel=2 num=f", sel, num);
        end
      end
      model_advance();
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset_midframe();
    exp_t e, got;
    do_reset();
    load_count();
    hold     = 1'b0;
    digit_en = 8'hFE;
    for (int j = 0; j < 5 * DIV + 2; j++) begin
      model_advance();
      @(posedge clk); #1;
    end
    n_cmp++;
    if (sel !== 3'd5) begin
      n_bad++;
      $display("FAIL midreset_pre: got sel=%0d, expected 5", sel);
    end
    #2 rst_n = 1'b0;
    #1;
    got = {sel, num, blank, frame_done};
    n_cmp++;
    if (got !== {3'd0, 4'h0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL midreset_async: got sel=%0d num=%h blank=%b fd=%b, expected sel=0 num=0 blank=1 fd=0",
               sel, num, blank, frame_done);
    end
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < 8 * DIV + 2; j++) begin
      exp_q.push_back(model_expect());
      #1;
      got = {sel, num, blank, frame_done};
      e   = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL midreset j=%0d: got sel=%0d num=%h blank=%b fd=%b, expected sel=%0d num=%h blank=%b fd=%b",
                 j, got.sel, got.num, got.blank, got.fd, e.sel, e.num, e.blank, e.fd);
      end
      model_advance();
      @(posedge clk); #1;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scan();
    test_hold();
    test_write_on_advance();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
